// File: rtl/mips_core.sv
// Single-cycle 32-bit MIPS subset CPU (add/sub/and/or/slt, lw/sw/beq/addi) with internal memories.
// Define MIPS_JUMP_EN to add j/jal; without it those opcodes execute as NOPs.

module mips_ram #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset branch; program and data survive rst and need no reset fan-out.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module mips_core #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    output logic [31:0] debug_data,
    input  logic [4:0]  debug_addr,
    input  logic        rst,
    input  logic        clk
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_SLT = 6'h2A
    } funct_t;

    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] regs [32];
    logic [31:0] instr, dmem_rdata;
    logic [31:0] rs_val, rt_val, imm_sext, mem_addr;
    logic [4:0]  rs, rt, rd, reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_we, dmem_we;
    opcode_t     opcode;
    funct_t      funct;

    mips_ram #(.DEPTH(IMEM_DEPTH)) mips_i_mem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc[IAW+1:2]),
        .wdata (32'd0),
        .rdata (instr)
    );

    mips_ram #(.DEPTH(DMEM_DEPTH)) mips_d_mem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (mem_addr[DAW+1:2]),
        .wdata (rt_val),
        .rdata (dmem_rdata)
    );

    assign opcode   = opcode_t'(instr[31:26]);
    assign funct    = funct_t'(instr[5:0]);
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};

    assign rs_val     = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val     = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign debug_data = (debug_addr == 5'd0) ? 32'd0 : regs[debug_addr];

    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs_val + imm_sext;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        pc_next   = pc_plus4;
        reg_we    = 1'b0;
        reg_waddr = rd;
        reg_wdata = 32'd0;
        dmem_we   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD:  reg_wdata = rs_val + rt_val;
                    FN_SUB:  reg_wdata = rs_val - rt_val;
                    FN_AND:  reg_wdata = rs_val & rt_val;
                    FN_OR:   reg_wdata = rs_val | rt_val;
                    FN_SLT:  reg_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    default: reg_we    = 1'b0;
                endcase
            end
            OP_ADDI: begin
                reg_we    = 1'b1;
                reg_waddr = rt;
                reg_wdata = mem_addr;
            end
            OP_LW: begin
                reg_we    = 1'b1;
                reg_waddr = rt;
                reg_wdata = dmem_rdata;
            end
            OP_SW:  dmem_we = 1'b1;
            OP_BEQ: if (rs_val == rt_val) pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
`ifdef MIPS_JUMP_EN
            OP_J:   pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
            OP_JAL: begin
                pc_next   = {pc_plus4[31:28], instr[25:0], 2'b00};
                reg_we    = 1'b1;
                reg_waddr = 5'd31;
                reg_wdata = pc_plus4;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all reads in a cycle see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= pc_next;
            if (reg_we && reg_waddr != 5'd0) regs[reg_waddr] <= reg_wdata;
        end
    end
endmodule

// File: tb/tb_mips_core.sv
// Scoreboard bench for mips_core: expectations are queued per program and drained with the clock parked.
module tb_mips_core;
    logic        clk = 1'b0;
    logic        clk_run = 1'b1;
    logic        rst = 1'b1;
    logic [4:0]  debug_addr = 5'd0;
    logic [31:0] debug_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {K_REG, K_MEM, K_PC} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];

    mips_core dut (
        .debug_data (debug_data),
        .debug_addr (debug_addr),
        .rst        (rst),
        .clk        (clk)
    );

    always #5 if (clk_run) clk = ~clk;

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input kind_e kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Clock is parked low while expectations are compared against the frozen core.
    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        clk_run = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_REG: begin
                    debug_addr = e.idx[4:0];
                    #1;
                    got = debug_data;
                end
                K_MEM:   got = dut.mips_d_mem.mem[e.idx];
                default: got = dut.pc;
            endcase
            check(e.tag, got, e.val);
        end
        clk_run = 1'b1;
    endtask

    task automatic boot();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dut.mips_i_mem.mem[i] = 32'd0;
            dut.mips_d_mem.mem[i] = 32'd0;
        end
        for (int i = 0; i < prog.size(); i++) dut.mips_i_mem.mem[i] = prog[i];
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state before any edge executes
        prog = '{i_op(6'h08, 5'd0, 5'd5, 16'd9)};
        boot();
        expect_val("reset_pc", K_PC, 0, 32'd0);
        expect_val("reset_r5", K_REG, 5, 32'd0);
        drain();

        // ALU
        prog = '{i_op(6'h08, 5'd0, 5'd8, 16'd5),
                 i_op(6'h08, 5'd0, 5'd9, 16'hFFFD),
                 r_op(5'd8, 5'd9, 5'd10, 6'h20),
                 r_op(5'd9, 5'd8, 5'd11, 6'h2A),
                 r_op(5'd8, 5'd9, 5'd12, 6'h22),
                 r_op(5'd8, 5'd9, 5'd13, 6'h24),
                 r_op(5'd8, 5'd9, 5'd14, 6'h25),
                 r_op(5'd8, 5'd9, 5'd15, 6'h2A)};
        boot();
        run(3);
        expect_val("add_r10", K_REG, 10, 32'd2);
        drain();
        run(5);
        expect_val("addi_neg_r9", K_REG, 9, 32'hFFFF_FFFD);
        expect_val("slt_true_r11", K_REG, 11, 32'd1);
        expect_val("sub_r12", K_REG, 12, 32'd8);
        expect_val("and_r13", K_REG, 13, 32'd5);
        expect_val("or_r14", K_REG, 14, 32'hFFFF_FFFD);
        expect_val("slt_false_r15", K_REG, 15, 32'd0);
        drain();

        // Memory, then reset in mid-program
        prog = '{i_op(6'h23, 5'd0, 5'd8, 16'd8),
                 i_op(6'h2B, 5'd0, 5'd8, 16'd12),
                 i_op(6'h08, 5'd0, 5'd1, 16'd16),
                 i_op(6'h23, 5'd1, 5'd2, 16'hFFFC)};
        boot();
        dut.mips_d_mem.mem[2] = 32'h0000_1234;
        run(4);
        expect_val("lw_r8", K_REG, 8, 32'h0000_1234);
        expect_val("sw_dmem3", K_MEM, 3, 32'h0000_1234);
        expect_val("lw_negoff_r2", K_REG, 2, 32'h0000_1234);
        expect_val("mem_pc", K_PC, 0, 32'd16);
        drain();
        rst = 1'b1;
        #1;
        expect_val("midrst_pc", K_PC, 0, 32'd0);
        expect_val("midrst_r8", K_REG, 8, 32'd0);
        expect_val("midrst_r1", K_REG, 1, 32'd0);
        expect_val("midrst_dmem3", K_MEM, 3, 32'h0000_1234);
        drain();

        // Branch
        prog = '{i_op(6'h04, 5'd0, 5'd0, 16'd1),
                 i_op(6'h08, 5'd0, 5'd8, 16'd9),
                 i_op(6'h08, 5'd0, 5'd9, 16'd7)};
        boot();
        run(2);
        expect_val("beq_pc", K_PC, 0, 32'd12);
        expect_val("beq_skip_r8", K_REG, 8, 32'd0);
        drain();
        run(1);
        expect_val("beq_after_r9", K_REG, 9, 32'd7);
        drain();

        // Write to $0 discarded
        prog = '{i_op(6'h08, 5'd0, 5'd0, 16'd7)};
        boot();
        run(1);
        expect_val("r0_const", K_REG, 0, 32'd0);
        drain();

        // jal
        prog = '{32'h0C00_0004};
        boot();
        run(1);
`ifdef MIPS_JUMP_EN
        expect_val("jal_pc", K_PC, 0, 32'h0000_0010);
        expect_val("jal_r31", K_REG, 31, 32'd4);
`else
        expect_val("jal_pc", K_PC, 0, 32'd4);
        expect_val("jal_r31", K_REG, 31, 32'd0);
`endif
        drain();

        // Unsupported funct and opcode are NOPs
        prog = '{i_op(6'h08, 5'd0, 5'd9, 16'd3),
                 r_op(5'd9, 5'd9, 5'd8, 6'h21),
                 i_op(6'h3F, 5'd9, 5'd10, 16'd5)};
        boot();
        run(3);
        expect_val("nop_r9", K_REG, 9, 32'd3);
        expect_val("bad_funct_r8", K_REG, 8, 32'd0);
        expect_val("bad_op_r10", K_REG, 10, 32'd0);
        expect_val("nop_pc", K_PC, 0, 32'd12);
        drain();

        // PC wraps through the instruction memory by index truncation
        prog = '{i_op(6'h08, 5'd8, 5'd8, 16'd1)};
        boot();
        run(65);
        expect_val("wrap_pc", K_PC, 0, 32'd260);
        expect_val("wrap_r8", K_REG, 8, 32'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
